// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller: FSM state enum,
// default limits and the canned stage-control rows used by the priority mux.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } ctrl_state_e;

  localparam int WAIT_LIMIT_DEF = 16;
  localparam int CNT_W_DEF      = 16;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_flush;
  } stage_ctrl_t;

  // One row per priority level; the top picks exactly one of these per cycle.
  localparam stage_ctrl_t CTRL_HALT     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam stage_ctrl_t CTRL_MEMSTALL = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam stage_ctrl_t CTRL_BRANCH   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam stage_ctrl_t CTRL_LOADUSE  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam stage_ctrl_t CTRL_JUMP     = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam stage_ctrl_t CTRL_NORMAL   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc high and sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}}))
      count_d = count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: memory-wait FSM with timeout, load-use
// detection, prioritised stage enables/flushes and stall performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             mem_memread,
  input  logic             mem_memwrite,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             err,
  output logic [CNT_W-1:0] lu_stalls,
  output logic [CNT_W-1:0] mem_stalls
);

  localparam int WCNT_W = $clog2(WAIT_LIMIT + 1);

  ctrl_state_e       state_q, state_d, cur_state;
  logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_acc, in_err, memstall, loaduse, lu_sel;
  stage_ctrl_t       ctrl;

  // Reset is synchronous, so during the reset cycle the outputs behave as RUN.
  assign cur_state = rst ? ST_RUN : state_q;
  assign in_err    = (cur_state == ST_ERR);
  assign mem_acc   = mem_memread | mem_memwrite;
  assign dmem_req  = mem_acc & ~in_err;
  assign memstall  = mem_acc & ~dmem_ack & ~in_err;
  assign loaduse   = ex_memread & (ex_rd != 5'd0) &
                     ((id_uses_rs & (ex_rd == id_rs)) | (id_uses_rt & (ex_rd == id_rt)));

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (memstall) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WCNT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ack) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WCNT_W'(WAIT_LIMIT)) begin
          state_d = ST_ERR;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      ST_ERR: begin
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // A taken branch squashes the ID instruction, so a coincident load-use is moot.
  always_comb begin
    ctrl   = CTRL_NORMAL;
    lu_sel = 1'b0;
    if (in_err) begin
      ctrl = CTRL_HALT;
    end else if (memstall) begin
      ctrl = CTRL_MEMSTALL;
    end else if (ex_branch_taken) begin
      ctrl = CTRL_BRANCH;
    end else if (loaduse) begin
      ctrl   = CTRL_LOADUSE;
      lu_sel = 1'b1;
    end else if (id_jump) begin
      ctrl = CTRL_JUMP;
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign ifid_en     = ctrl.ifid_en;
  assign idex_en     = ctrl.idex_en;
  assign exmem_en    = ctrl.exmem_en;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_flush  = ctrl.idex_flush;
  assign memwb_flush = ctrl.memwb_flush;
  assign err         = in_err;

  sat_counter #(.W(CNT_W)) u_lu_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (lu_sel),
    .count (lu_stalls)
  );

  sat_counter #(.W(CNT_W)) u_mem_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (memstall),
    .count (mem_stalls)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_pipe_ctrl;

  localparam int WAIT_LIMIT = 16;
  localparam int CNT_W      = 4;
  localparam int CNT_MAX    = 15;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs, id_rt, ex_rd;
  logic             id_uses_rs, id_uses_rt, id_jump;
  logic             ex_memread, ex_branch_taken;
  logic             mem_memread, mem_memwrite, dmem_ack;
  logic             dmem_req, pc_en, ifid_en, idex_en, exmem_en;
  logic             ifid_flush, idex_flush, memwb_flush, err;
  logic [CNT_W-1:0] lu_stalls, mem_stalls;

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  // Model state: whether a memory wait is in progress, how long it has lasted,
  // whether the timeout fired, and the two stall tallies.
  bit m_waiting = 1'b0;
  bit m_err     = 1'b0;
  int m_waited  = 0;
  int m_lu      = 0;
  int m_mem     = 0;

  logic [8:0] cmp_exp, cmp_act;
  bit         cmp_lu, cmp_mem;
  bit         slow_mem;

  pipe_ctrl #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_jump         (id_jump),
    .ex_rd           (ex_rd),
    .ex_memread      (ex_memread),
    .ex_branch_taken (ex_branch_taken),
    .mem_memread     (mem_memread),
    .mem_memwrite    (mem_memwrite),
    .dmem_ack        (dmem_ack),
    .dmem_req        (dmem_req),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .idex_en         (idex_en),
    .exmem_en        (exmem_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .memwb_flush     (memwb_flush),
    .err             (err),
    .lu_stalls       (lu_stalls),
    .mem_stalls      (mem_stalls)
  );

  always #5 clk = ~clk;

  // Expected {dmem_req, pc/ifid/idex/exmem enables, ifid/idex/memwb flushes, err}
  // chosen straight from the priority rules.
  function automatic logic [8:0] model_outputs(output bit lu_row, output bit mem_row);
    bit halted, acc, stall, hazard;
    halted  = !rst && m_err;
    acc     = mem_memread || mem_memwrite;
    stall   = acc && !dmem_ack && !halted;
    hazard  = ex_memread && (ex_rd != 0) &&
              ((id_uses_rs && ex_rd == id_rs) || (id_uses_rt && ex_rd == id_rt));
    lu_row  = 1'b0;
    mem_row = stall;
    if (halted)               return {1'b0, 4'b0000, 3'b000, 1'b1};
    else if (stall)           return {1'b1, 4'b0000, 3'b001, 1'b0};
    else if (ex_branch_taken) return {acc,  4'b1111, 3'b110, 1'b0};
    else if (hazard) begin
      lu_row = 1'b1;
      return {acc, 4'b0011, 3'b010, 1'b0};
    end
    else if (id_jump)         return {acc,  4'b1111, 3'b100, 1'b0};
    else                      return {acc,  4'b1111, 3'b000, 1'b0};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s at %0t: actual=%0d required=%0d", name, $time, actual, required);
    end
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_jump = 1'b0;
    ex_memread = 1'b0; ex_branch_taken = 1'b0;
    mem_memread = 1'b0; mem_memwrite = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic doReset();
    idleInputs();
    rst = 1'b1;
    applyStimulus(2);
    rst = 1'b0;
    #1;
  endtask

  task automatic loadUseInputs();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
  endtask

  // Per-cycle compare against the model, then advance the model across the next edge.
  initial forever begin
    @(negedge clk);
    if (model_on) begin
      cmp_exp = model_outputs(cmp_lu, cmp_mem);
      cmp_act = {dmem_req, pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush, err};
      checks++;
      if (cmp_act !== cmp_exp) begin
        errors++;
        $display("[TB] FAIL ctrl_vec at %0t: actual=%b required=%b", $time, cmp_act, cmp_exp);
      end
      checkOutput("lu_stalls_model", 32'(lu_stalls), 32'(m_lu));
      checkOutput("mem_stalls_model", 32'(mem_stalls), 32'(m_mem));
      if (rst) begin
        m_waiting = 1'b0; m_err = 1'b0; m_waited = 0; m_lu = 0; m_mem = 0;
      end else begin
        if (cmp_lu && m_lu < CNT_MAX)   m_lu++;
        if (cmp_mem && m_mem < CNT_MAX) m_mem++;
        if (!m_err) begin
          if (!m_waiting) begin
            if (cmp_mem) begin
              m_waiting = 1'b1;
              m_waited  = 1;
            end
          end else if (dmem_ack) begin
            m_waiting = 1'b0;
          end else if (m_waited == WAIT_LIMIT) begin
            m_err     = 1'b1;
            m_waiting = 1'b0;
          end else begin
            m_waited++;
          end
        end
      end
    end
  end

  initial begin
    idleInputs();
    rst = 1'b1;
    applyStimulus(2);
    model_on = 1'b1;
    rst = 1'b0;
    #1;
    checkOutput("reset_lu_stalls", 32'(lu_stalls), 0);
    checkOutput("reset_mem_stalls", 32'(mem_stalls), 0);
    checkOutput("reset_err", 32'(err), 0);
    checkOutput("reset_pc_en", 32'(pc_en), 1);

    loadUseInputs();
    #1;
    checkOutput("lu_pc_en", 32'(pc_en), 0);
    checkOutput("lu_ifid_en", 32'(ifid_en), 0);
    checkOutput("lu_idex_en", 32'(idex_en), 1);
    checkOutput("lu_idex_flush", 32'(idex_flush), 1);
    checkOutput("lu_count_before", 32'(lu_stalls), 0);
    applyStimulus(1);
    checkOutput("lu_count_after", 32'(lu_stalls), 1);

    ex_rd = 5'd0; id_rs = 5'd0;
    #1;
    checkOutput("r0_pc_en", 32'(pc_en), 1);
    checkOutput("r0_ifid_en", 32'(ifid_en), 1);
    checkOutput("r0_idex_flush", 32'(idex_flush), 0);
    applyStimulus(1);
    checkOutput("r0_lu_count", 32'(lu_stalls), 1);

    doReset();
    mem_memread = 1'b1; dmem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("mw_pc_en", 32'(pc_en), 0);
      checkOutput("mw_exmem_en", 32'(exmem_en), 0);
      checkOutput("mw_memwb_flush", 32'(memwb_flush), 1);
      checkOutput("mw_dmem_req", 32'(dmem_req), 1);
      applyStimulus(1);
    end
    dmem_ack = 1'b1;
    #1;
    checkOutput("mw_release_pc_en", 32'(pc_en), 1);
    checkOutput("mw_release_memwb_flush", 32'(memwb_flush), 0);
    applyStimulus(1);
    checkOutput("mw_mem_stalls", 32'(mem_stalls), 3);
    mem_memread = 1'b0; dmem_ack = 1'b0;

    doReset();
    loadUseInputs();
    ex_branch_taken = 1'b1;
    #1;
    checkOutput("br_ifid_flush", 32'(ifid_flush), 1);
    checkOutput("br_idex_flush", 32'(idex_flush), 1);
    checkOutput("br_pc_en", 32'(pc_en), 1);
    applyStimulus(1);
    checkOutput("br_lu_stalls", 32'(lu_stalls), 0);

    doReset();
    mem_memwrite = 1'b1; dmem_ack = 1'b0;
    applyStimulus(16);
    checkOutput("to_err_before", 32'(err), 0);
    checkOutput("to_pc_en_before", 32'(pc_en), 0);
    applyStimulus(1);
    checkOutput("to_err", 32'(err), 1);
    checkOutput("to_pc_en", 32'(pc_en), 0);
    checkOutput("to_exmem_en", 32'(exmem_en), 0);
    checkOutput("to_memwb_flush", 32'(memwb_flush), 0);
    checkOutput("to_dmem_req", 32'(dmem_req), 0);
    checkOutput("to_mem_stalls_sat", 32'(mem_stalls), 15);
    dmem_ack = 1'b1;
    applyStimulus(2);
    checkOutput("to_err_sticky", 32'(err), 1);
    checkOutput("to_pc_en_sticky", 32'(pc_en), 0);
    rst = 1'b1;
    #1;
    checkOutput("to_rst_cycle_pc_en", 32'(pc_en), 1);
    checkOutput("to_rst_cycle_err", 32'(err), 0);
    applyStimulus(1);
    rst = 1'b0;
    idleInputs();
    #1;
    checkOutput("to_cleared_err", 32'(err), 0);
    checkOutput("to_cleared_mem_stalls", 32'(mem_stalls), 0);

    doReset();
    loadUseInputs();
    applyStimulus(20);
    checkOutput("sat_lu_20", 32'(lu_stalls), 15);
    applyStimulus(3);
    checkOutput("sat_lu_hold", 32'(lu_stalls), 15);

    slow_mem = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 256 == 0) slow_mem = !slow_mem;
      rst             = ($urandom_range(0, 149) == 0);
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      id_uses_rs      = 1'($urandom_range(0, 1));
      id_uses_rt      = 1'($urandom_range(0, 1));
      id_jump         = ($urandom_range(0, 3) == 0);
      ex_memread      = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      mem_memread     = ($urandom_range(0, 2) == 0);
      mem_memwrite    = ($urandom_range(0, 2) == 0);
      dmem_ack        = slow_mem ? ($urandom_range(0, 39) == 0) : 1'($urandom_range(0, 1));
      applyStimulus(1);
    end
    idleInputs();
    rst = 1'b0;
    applyStimulus(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter WAIT_LIMIT, default 16: maximum MEM_WAIT cycles before the block declares an error.
REQ-002 Parameter CNT_W, default 16: width of the stall performance counters.
REQ-003 clk  in  1  clock; all state updates on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-006 id_uses_rs, id_uses_rt  in  1 each  high when the ID instruction reads that source.
REQ-007 id_jump  in  1  jump decoded in ID.
REQ-008 ex_rd  in  5  destination register of the instruction in EX.
REQ-009 ex_memread  in  1  EX instruction is a load.
REQ-010 ex_branch_taken  in  1  branch resolved taken in EX.
REQ-011 mem_memread, mem_memwrite  in  1 each  MemRead/MemWrite at the EX/MEM register outputs.
REQ-012 dmem_ack  in  1  data memory completes the access this cycle.
REQ-013 dmem_req  out  1  data memory request.
REQ-014 pc_en, ifid_en, idex_en, exmem_en  out  1 each  stage-register load enables.
REQ-015 ifid_flush, idex_flush, memwb_flush  out  1 each  insert a bubble (clear controls) into that register.
REQ-016 err  out  1  sticky memory-timeout error.
REQ-017 lu_stalls, mem_stalls  out  CNT_W each  saturating stall-cycle counters.

Function
REQ-018 FSM states: RUN, MEM_WAIT, ERR; encoding is a 2-bit enum.
REQ-019 mem_acc = mem_memread | mem_memwrite.
REQ-020 dmem_req = mem_acc & (state != ERR), combinational.
REQ-021 memstall = mem_acc & ~dmem_ack & (state != ERR).
REQ-022 Transition RUN -> MEM_WAIT on memstall; the wait counter loads 1.
REQ-023 Transition MEM_WAIT -> RUN on dmem_ack; release occurs in the ack cycle, so there is zero added latency after ack.
REQ-024 In MEM_WAIT without ack, the wait counter increments.
REQ-025 Transition MEM_WAIT -> ERR when the wait counter equals WAIT_LIMIT and dmem_ack=0.
REQ-026 ERR is left only by rst.
REQ-027 Hazard: loaduse = ex_memread & (ex_rd != 0) & ((id_uses_rs & ex_rd == id_rs) | (id_uses_rt & ex_rd == id_rt)).
REQ-028 Output priority, highest first: ERR > memstall > ex_branch_taken > loaduse > id_jump > normal.
- ERR: all enables 0, all flushes 0, err=1.
- memstall: all enables 0, memwb_flush=1, other flushes 0.
- branch: all enables 1, ifid_flush=1, idex_flush=1; a loaduse in the same cycle is ignored.
- loaduse: pc_en=0, ifid_en=0, idex_en=1, exmem_en=1, idex_flush=1.
- jump: all enables 1, ifid_flush=1.
- normal: all enables 1, all flushes 0.
REQ-029 Enable and flush outputs are combinational from the current state and inputs.
REQ-030 lu_stalls increments each cycle the loaduse row is selected.
REQ-031 mem_stalls increments each memstall cycle.
REQ-032 Both counters hold at all-ones; they never wrap.
REQ-033 The write of register 0 never causes a stall.

Reset
REQ-034 On rst the block enters RUN, with wait counter=0, err=0, lu_stalls=0, mem_stalls=0.
REQ-035 rst has priority over every transition, including a reset mid-MEM_WAIT or in ERR.
REQ-036 During the rst cycle, combinational outputs follow the RUN rules.

Structure
REQ-037 The state enum and the default WAIT_LIMIT constant belong in the shared cpu package.
REQ-038 One sub-module, sat_counter (parameterised width, inc, rst), is instantiated twice for the stall counters.
REQ-039 The FSM and the hazard logic remain in pipe_ctrl.

Verification
REQ-040 Load-use: ex_memread=1, ex_rd=5, id_rs=5, id_uses_rs=1 -> pc_en=0, ifid_en=0, idex_flush=1, and lu_stalls goes 0->1 on the next edge.
REQ-041 Register 0: ex_rd=0 with otherwise matching load-use inputs -> no stall, all enables 1.
REQ-042 Memory wait: mem_memread=1 with dmem_ack low for 3 cycles, then high -> enables 0 and memwb_flush=1 for 3 cycles, release in the 4th cycle, mem_stalls=3.
REQ-043 Priority: ex_branch_taken=1 together with loaduse -> ifid_flush=1, idex_flush=1, pc_en=1, and lu_stalls unchanged.
REQ-044 Timeout: mem_memwrite=1 with dmem_ack=0 for 17 cycles (WAIT_LIMIT=16) -> err=1 and all enables 0; a later dmem_ack has no effect; rst clears the error and returns to RUN.
REQ-045 Saturation: with CNT_W=4, hold loaduse for 20 cycles -> lu_stalls=15 and stays at 15.
